// File: rtl/car_link_responder.sv
// UART command responder for the car link: decodes 8N1 command bytes from rx
// and answers each accepted command with a {4'b1010, detector_in} status byte on tx.
module car_link_responder #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [3:0] detector_in,
  output logic       tx,
  output logic       cmd_valid,
  output logic [5:0] move_cmd,
  output logic       frame_error,
  output logic       tx_busy
);

  localparam int CW = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          rx_meta, rx_sync;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_byte;

  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          pending;
  logic [7:0]    pend_byte;
  logic [7:0]    reply_byte;

  assign reply_byte = {4'b1010, detector_in};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two-stage synchronizer into one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state    <= S_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_byte     <= '0;
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
      move_cmd    <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (!rx_sync) rx_state <= S_START;
        end
        S_START: begin
          // A start bit that is no longer low at its midpoint was a glitch.
          if (rx_cnt == MID) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == LAST) begin
            rx_cnt  <= '0;
            rx_byte <= {rx_sync, rx_byte[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt == LAST) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
            if (rx_sync && rx_byte[7:6] == 2'b00) begin
              cmd_valid <= 1'b1;
              move_cmd  <= rx_byte[5:0];
            end else begin
              frame_error <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      pending   <= 1'b0;
      pend_byte <= '0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx_cnt <= '0;
          tx_bit <= '0;
          // A fresh command carries the newest detector sample, so it wins over a pending one.
          if (cmd_valid || pending) begin
            tx_shift <= cmd_valid ? reply_byte : pend_byte;
            pending  <= 1'b0;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
      // Requests arriving mid-reply coalesce into one pending reply.
      if (cmd_valid && tx_state != S_IDLE) begin
        pending   <= 1'b1;
        pend_byte <= reply_byte;
      end
    end
  end

endmodule

// File: tb/tb_car_link_responder.sv
// Randomized bench for car_link_responder: drives 8N1 frames on rx and checks
// decode results and the tx line cycle by cycle against a timing-level reply model.
module tb_car_link_responder;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [3:0] detector_in = 4'd0;
  logic       tx, cmd_valid, frame_error, tx_busy;
  logic [5:0] move_cmd;

  always #5 clk = ~clk;

  car_link_responder #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .detector_in (detector_in),
    .tx          (tx),
    .cmd_valid   (cmd_valid),
    .move_cmd    (move_cmd),
    .frame_error (frame_error),
    .tx_busy     (tx_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Detector driver: random every cycle unless a test pins it.
  bit         det_hold = 1'b0;
  logic [3:0] det_val  = 4'd0;
  initial forever begin
    @(posedge clk);
    #1;
    detector_in = det_hold ? det_val : 4'($urandom);
  end

  // Reply model: a reply occupies FRAME cycles starting the cycle after its
  // request; requests during a reply leave one pending reply with the newest sample.
  logic       rst_q = 1'b1;
  int         cyc = 0;
  int         m_start = -1000;
  logic [7:0] m_byte = 8'h00;
  bit         m_pend = 1'b0;
  logic [3:0] m_pend_det = 4'd0;
  bit         armed = 1'b0;
  int         cv_cnt = 0;
  int         fe_cnt = 0;

  always @(posedge clk) rst_q <= reset;

  function automatic logic exp_tx_at(input int c);
    int k;
    if (!(c >= m_start && c < m_start + FRAME)) return 1'b1;
    k = (c - m_start) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  always @(negedge clk) begin
    bit busy;
    cyc++;
    if (rst_q) begin
      armed   = 1'b1;
      m_start = -1000;
      m_pend  = 1'b0;
      check("rst_tx", tx, 1'b1);
      check("rst_tx_busy", tx_busy, 1'b0);
      check("rst_cmd_valid", cmd_valid, 1'b0);
      check("rst_frame_error", frame_error, 1'b0);
    end else if (armed) begin
      busy = (cyc >= m_start && cyc < m_start + FRAME);
      check("tx_busy", tx_busy, busy);
      check("tx_line", tx, exp_tx_at(cyc));
      if (cmd_valid)   cv_cnt++;
      if (frame_error) fe_cnt++;
      if (cmd_valid) begin
        if (!busy) begin
          m_start = cyc + 1;
          m_byte  = {4'b1010, detector_in};
          m_pend  = 1'b0;
        end else begin
          m_pend     = 1'b1;
          m_pend_det = detector_in;
        end
      end else if (m_pend && !busy) begin
        m_start = cyc + 1;
        m_byte  = {4'b1010, m_pend_det};
        m_pend  = 1'b0;
      end
    end
  end

  logic [5:0] exp_move = 6'd0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame; abort_at > 0 asserts reset that many cycles into it.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int abort_at);
    int k;
    logic v;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? 1'b0 : (i == 9) ? stop_bit : b[i-1];
      for (int j = 0; j < CPB; j++) begin
        if (abort_at > 0 && k == abort_at) begin
          rx    = 1'b1;
          reset = 1'b1;
          tick(2);
          reset = 1'b0;
          return;
        end
        rx = v;
        tick(1);
        k++;
      end
    end
    rx = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit stop_bit,
                           input int abort_at);
    int  cv0, fe0;
    bit  acc;
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send_frame(b, stop_bit, abort_at);
    tick(8);
    acc = (abort_at == 0) && stop_bit && (b[7:6] == 2'b00);
    if (abort_at > 0) exp_move = 6'd0;
    else if (acc)     exp_move = b[5:0];
    check({tag, "_cmd_valid"}, cv_cnt - cv0, acc);
    check({tag, "_frame_error"}, fe_cnt - fe0, (abort_at == 0 && !acc));
    check({tag, "_move_cmd"}, move_cmd, exp_move);
  endtask

  initial begin
    int cv0, fe0;
    logic [7:0] b;
    bit sb;

    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_move_cmd", move_cmd, 6'd0);
    check("reset_tx", tx, 1'b1);
    check("reset_tx_busy", tx_busy, 1'b0);

    det_val  = 4'b1001;
    det_hold = 1'b1;
    tick(2);
    run_frame("forward", 8'h01, 1'b1, 0);
    tick(FRAME + 5);
    det_hold = 1'b0;

    run_frame("bad_marker", 8'hC3, 1'b1, 0);
    run_frame("bad_stop", 8'h05, 1'b0, 0);

    cv0 = cv_cnt;
    fe0 = fe_cnt;
    rx  = 1'b0;
    tick(1);
    rx  = 1'b1;
    tick(10);
    check("glitch_cmd_valid", cv_cnt - cv0, 0);
    check("glitch_frame_error", fe_cnt - fe0, 0);
    run_frame("after_glitch", 8'h20, 1'b1, 0);
    tick(FRAME + 5);

    // Back-to-back commands while replies are still being sent.
    cv0 = cv_cnt;
    send_frame(8'h04, 1'b1, 0);
    send_frame(8'h08, 1'b1, 0);
    send_frame(8'h10, 1'b1, 0);
    tick(8);
    check("coalesce_cmd_count", cv_cnt - cv0, 3);
    check("coalesce_move_cmd", move_cmd, 6'b010000);
    exp_move = 6'b010000;
    tick(3 * FRAME + 10);

    run_frame("pre_abort", 8'h08, 1'b1, 0);
    run_frame("abort", 8'h11, 1'b1, 16);
    tick(5);
    run_frame("after_abort", 8'h02, 1'b1, 0);
    check("after_abort_value", move_cmd, 6'b000010);
    tick(FRAME + 5);

    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 2) != 0) b[7:6] = 2'b00;
      sb = ($urandom_range(0, 5) != 0);
      run_frame("random", b, sb, 0);
      tick($urandom_range(0, 50));
    end

    tick(2 * FRAME + 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
